// File: rtl/alu_sweep_ctrl_if.sv
// Bus between the ALU sweep controller and its environment (ALU plus host).
// The slave side is the controller; the master side drives start and the ALU result.
interface alu_sweep_ctrl_if;
    logic       start;
    logic [3:0] y_in;
    logic [1:0] A_out;
    logic [1:0] B_out;
    logic [1:0] sel_out;
    logic [5:0] vec_idx;
    logic       busy;
    logic       done;
    logic [9:0] sum;
    logic [7:0] sig;
    logic [1:0] dbg_state;

    // start is a level request taken only in IDLE; done is a one-cycle completion strobe.
    modport master (
        output start, y_in,
        input  A_out, B_out, sel_out, vec_idx, busy, done, sum, sig, dbg_state
    );
    modport slave (
        input  start, y_in,
        output A_out, B_out, sel_out, vec_idx, busy, done, sum, sig, dbg_state
    );
endinterface

// File: rtl/alu_sweep_ctrl.sv
// Walks a 2-bit ALU through all 64 {A,B,sel} vectors and folds the sampled
// results into a running sum and an 8-bit rotate-XOR signature.
module alu_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_sweep_ctrl_if.slave  bus
);
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state, w_state_next;
    logic [3:0] r_cnt, w_cnt_next;
    logic [5:0] r_vec, w_vec_next;
    logic [9:0] r_sum, w_sum_next;
    logic [7:0] r_sig, w_sig_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_vec   <= 6'd0;
            r_sum   <= 10'd0;
            r_sig   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_vec   <= w_vec_next;
            r_sum   <= w_sum_next;
            r_sig   <= w_sig_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_vec_next   = r_vec;
        w_sum_next   = r_sum;
        w_sig_next   = r_sig;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = SETTLE_L;
                    w_vec_next   = 6'd0;
                    w_sum_next   = 10'd0;
                    w_sig_next   = 8'd0;
                end
            end
            S_WAIT: begin
                // Leaving when the count reads 1 yields exactly SETTLE cycles here.
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_sum_next = r_sum + {6'd0, bus.y_in};
                w_sig_next = {r_sig[6:0], r_sig[7]} ^ {4'b0000, bus.y_in};
                if (r_vec == 6'd63) begin
                    w_state_next = S_DONE;
                end else begin
                    w_vec_next   = r_vec + 6'd1;
                    w_cnt_next   = SETTLE_L;
                    w_state_next = S_WAIT;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.vec_idx   = r_vec;
    assign bus.A_out     = r_vec[5:4];
    assign bus.B_out     = r_vec[3:2];
    assign bus.sel_out   = r_vec[1:0];
    assign bus.sum       = r_sum;
    assign bus.sig       = r_sig;
    assign bus.busy      = (r_state == S_WAIT) || (r_state == S_SAMPLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.dbg_state = r_state;
endmodule
